// File: rtl/wb_debounce_pkg.sv
// Shared types and constants for the debounced-input event controller.
// Register offsets are word indices on adr[4:2].
package wb_debounce_pkg;

   localparam logic [2:0] REG_LEVEL   = 3'd0;
   localparam logic [2:0] REG_RISE_EN = 3'd1;
   localparam logic [2:0] REG_FALL_EN = 3'd2;
   localparam logic [2:0] REG_PENDING = 3'd3;
   localparam logic [2:0] REG_IRQ_EN  = 3'd4;
   localparam logic [2:0] REG_EVENT   = 3'd5;
   localparam logic [2:0] REG_OVF     = 3'd6;

   localparam int EVT_VALID    = 31;
   localparam int EVT_RISE     = 8;
   localparam int EVT_PORT_MSB = 4;
   localparam int EVT_PORT_LSB = 0;

   typedef struct packed {
      logic       valid;
      logic       rise;
      logic [4:0] port;
   } event_t;

   function automatic logic [31:0] evt_word(input event_t e);
      logic [31:0] w;
      w = '0;
      w[EVT_VALID] = e.valid;
      w[EVT_RISE]  = e.rise;
      w[EVT_PORT_MSB:EVT_PORT_LSB] = e.port;
      return w;
   endfunction

endpackage

// File: rtl/wishbone_p_if.sv
// Wishbone pipelined bus bundle with clock and reset.
// Signal directions in the slave modport are from the slave's point of view.
interface wishbone_p_if;
   logic        clk_i;
   logic        rst_i;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack;
   logic        stall;

   modport slave (
      input  clk_i, rst_i, cyc, stb, we, adr, dat_i,
      output dat_o, ack, stall
   );

   modport master (
      output clk_i, rst_i, cyc, stb, we, adr, dat_i,
      input  dat_o, ack, stall
   );
endinterface

// File: rtl/fifo_sync.sv
// First-word-fall-through synchronous FIFO, async active-high reset.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "fifo_sync: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_cnt == '0);
   assign full      = (r_cnt == (AW+1)'(DEPTH));
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign dout      = r_mem[r_rd];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
         r_cnt <= r_cnt + {{AW{1'b0}}, w_do_push}
                        - {{AW{1'b0}}, w_do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= din;
   end
endmodule

// File: rtl/wb_debounce_event_ctrl.sv
// Edge-detecting event/interrupt controller for debounced inputs.
// Edges latch PENDING and queue requests serialised into an event FIFO.
module wb_debounce_event_ctrl
   import wb_debounce_pkg::*;
#(
   parameter int PORT_CNT   = 8,
   parameter int FIFO_DEPTH = 8
) (
   wishbone_p_if.slave          wb,
   input  logic [PORT_CNT-1:0]  debounced_i,
   output logic                 irq_o
);
   if (PORT_CNT < 1 || PORT_CNT > 32) begin : g_bad_port_cnt
      $fatal(1, "wb_debounce_event_ctrl: PORT_CNT must be in [1,32]");
   end

   localparam logic [PORT_CNT-1:0] ONE = PORT_CNT'(1);

   logic [PORT_CNT-1:0] r_prev, r_rise_en, r_fall_en;
   logic [PORT_CNT-1:0] r_pend, r_irq_en, r_qr, r_qf;
   logic                r_ovf, r_irq;

   logic [PORT_CNT-1:0] w_rise, w_fall, w_wdat;
   logic [PORT_CNT-1:0] w_clr_r, w_clr_f, w_qr_keep, w_qf_keep;
   logic [PORT_CNT-1:0] w_pend_clr;
   logic [2:0]          w_addr;
   logic                w_ack, w_wr, w_rd, w_pop, w_push, w_lost;
   logic                w_any, w_sel_rise, w_full, w_empty;
   logic [4:0]          w_sel;
   logic [31:0]         w_rdat;
   event_t              w_evt, w_head;
   logic                w_unused;

   assign w_rise = debounced_i & ~r_prev & r_rise_en;
   assign w_fall = ~debounced_i & r_prev & r_fall_en;

   assign w_ack  = wb.cyc & wb.stb;
   assign w_wr   = w_ack & wb.we;
   assign w_rd   = w_ack & ~wb.we;
   assign w_addr = wb.adr[4:2];
   assign w_wdat = wb.dat_i[PORT_CNT-1:0];
   assign w_pop  = w_rd && (w_addr == REG_EVENT) && !w_empty;

   // Lowest port wins; within a port the rise request goes first.
   always_comb begin
      w_any      = 1'b0;
      w_sel      = '0;
      w_sel_rise = 1'b0;
      for (int i = PORT_CNT - 1; i >= 0; i--) begin
         if (r_qr[i] | r_qf[i]) begin
            w_any      = 1'b1;
            w_sel      = 5'(i);
            w_sel_rise = r_qr[i];
         end
      end
   end

   assign w_push  = w_any && (!w_full || w_pop);
   assign w_clr_r = (w_push && w_sel_rise)  ? (ONE << w_sel) : '0;
   assign w_clr_f = (w_push && !w_sel_rise) ? (ONE << w_sel) : '0;

   assign w_qr_keep = r_qr & ~w_clr_r;
   assign w_qf_keep = r_qf & ~w_clr_f;
   assign w_lost    = (|(w_rise & w_qr_keep)) | (|(w_fall & w_qf_keep));

   assign w_pend_clr = (w_wr && w_addr == REG_PENDING) ? w_wdat : '0;

   assign w_evt = '{valid: 1'b1, rise: w_sel_rise, port: w_sel};

   fifo_sync #(
      .WIDTH ($bits(event_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (wb.clk_i),
      .rst   (wb.rst_i),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_evt),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge wb.clk_i or posedge wb.rst_i) begin
      if (wb.rst_i) begin
         r_prev    <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
         r_pend    <= '0;
         r_irq_en  <= '0;
         r_qr      <= '0;
         r_qf      <= '0;
         r_ovf     <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_prev <= debounced_i;
         if (w_wr && w_addr == REG_RISE_EN) r_rise_en <= w_wdat;
         if (w_wr && w_addr == REG_FALL_EN) r_fall_en <= w_wdat;
         if (w_wr && w_addr == REG_IRQ_EN)  r_irq_en  <= w_wdat;
         // New edges override a concurrent W1C.
         r_pend <= (r_pend & ~w_pend_clr) | w_rise | w_fall;
         r_qr   <= w_qr_keep | w_rise;
         r_qf   <= w_qf_keep | w_fall;
         r_ovf  <= (r_ovf & ~(w_wr && w_addr == REG_OVF && wb.dat_i[0]))
                   | w_lost;
         r_irq  <= |(r_pend & r_irq_en);
      end
   end

   always_comb begin
      w_rdat = '0;
      case (w_addr)
         REG_LEVEL:   w_rdat = 32'(debounced_i);
         REG_RISE_EN: w_rdat = 32'(r_rise_en);
         REG_FALL_EN: w_rdat = 32'(r_fall_en);
         REG_PENDING: w_rdat = 32'(r_pend);
         REG_IRQ_EN:  w_rdat = 32'(r_irq_en);
         REG_EVENT:   w_rdat = w_empty ? 32'd0 : evt_word(w_head);
         REG_OVF:     w_rdat = {31'd0, r_ovf};
         default:     w_rdat = '0;
      endcase
   end

   assign wb.dat_o  = w_rd ? w_rdat : 32'd0;
   assign wb.ack    = w_ack;
   assign wb.stall  = 1'b0;
   assign irq_o     = r_irq;
   assign w_unused  = ^{wb.adr[31:5], wb.adr[1:0], wb.dat_i};
endmodule
